// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter for two requesters sharing a single-access RAM array.
// Registered grants with burst fairness and a registered read-data return per port.
module ram_port_arbiter #(
  parameter int unsigned DATA_WIDTH = 3,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] din_a,
  output logic                  gnt_a,
  output logic [DATA_WIDTH-1:0] dout_a,
  output logic                  valid_a,
  input  logic                  req_b,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] din_b,
  output logic                  gnt_b,
  output logic [DATA_WIDTH-1:0] dout_b,
  output logic                  valid_b,
  output logic                  busy
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, SERVE_A, SERVE_B} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] burst_cnt, cnt_next;
  logic             last_b, last_b_next;
  logic             gnt_a_next, gnt_b_next, busy_next;
  logic             commit_a, commit_b;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;

  assign commit_a = gnt_a & req_a;
  assign commit_b = gnt_b & req_b;

  // State register; grant and busy flops mirror the next state so they switch on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      burst_cnt <= '0;
      last_b    <= 1'b1;
      gnt_a     <= 1'b0;
      gnt_b     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      burst_cnt <= cnt_next;
      last_b    <= last_b_next;
      gnt_a     <= gnt_a_next;
      gnt_b     <= gnt_b_next;
      busy      <= busy_next;
    end
  end

  // Next-state: release on dropped req, hand over after MAX_BURST commits while the other waits
  always_comb begin
    state_next  = state;
    cnt_next    = burst_cnt;
    last_b_next = last_b;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (req_a && req_b) state_next = last_b ? SERVE_A : SERVE_B;
        else if (req_a)     state_next = SERVE_A;
        else if (req_b)     state_next = SERVE_B;
      end
      SERVE_A: begin
        if (!req_a) begin
          state_next  = req_b ? SERVE_B : IDLE;
          cnt_next    = '0;
          last_b_next = 1'b0;
        end else if (req_b) begin
          if (burst_cnt == CNT_LAST) begin
            state_next  = SERVE_B;
            cnt_next    = '0;
            last_b_next = 1'b0;
          end else begin
            cnt_next = burst_cnt + CNT_W'(1);
          end
        end else begin
          cnt_next = '0;
        end
      end
      SERVE_B: begin
        if (!req_b) begin
          state_next  = req_a ? SERVE_A : IDLE;
          cnt_next    = '0;
          last_b_next = 1'b1;
        end else if (req_a) begin
          if (burst_cnt == CNT_LAST) begin
            state_next  = SERVE_A;
            cnt_next    = '0;
            last_b_next = 1'b1;
          end else begin
            cnt_next = burst_cnt + CNT_W'(1);
          end
        end else begin
          cnt_next = '0;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Output decode of the next state, captured by the state register
  always_comb begin
    gnt_a_next = 1'b0;
    gnt_b_next = 1'b0;
    busy_next  = 1'b0;
    gnt_a_next = (state_next == SERVE_A);
    gnt_b_next = (state_next == SERVE_B);
    busy_next  = (state_next != IDLE);
  end

  // Single write port: at most one side commits per cycle
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = addr_a;
    mem_din  = din_a;
    if (commit_a && we_a) begin
      mem_we = 1'b1;
    end else if (commit_b && we_b) begin
      mem_we   = 1'b1;
      mem_addr = addr_b;
      mem_din  = din_b;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
  end

  // Read return path: data held between reads, valid pulses for one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_a  <= '0;
      dout_b  <= '0;
      valid_a <= 1'b0;
      valid_b <= 1'b0;
    end else begin
      valid_a <= commit_a & ~we_a;
      valid_b <= commit_b & ~we_b;
      if (commit_a && !we_a) dout_a <= mem[addr_a];
      if (commit_b && !we_b) dout_b <= mem[addr_b];
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: reset, single-port access, fairness,
// long single-owner bursts, cross-port ordering and reset abort.
module tb_ram_port_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
  logic [2:0] addr_a = '0, din_a = '0, addr_b = '0, din_b = '0;
  logic       gnt_a, gnt_b, valid_a, valid_b, busy;
  logic [2:0] dout_a, dout_b;

  int n_checks = 0;
  int n_fail   = 0;

  ram_port_arbiter #(.DATA_WIDTH(3), .ADDR_WIDTH(3), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a),
    .gnt_a(gnt_a), .dout_a(dout_a), .valid_a(valid_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b),
    .gnt_b(gnt_b), .dout_b(dout_b), .valid_b(valid_b),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_a = 1'b0; req_b = 1'b0;
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  // One transaction on side A (sb=0) or B (sb=1); checks read data when a read
  task automatic xact(input bit sb, input logic w, input logic [2:0] ad,
                      input logic [2:0] dn, input logic [2:0] exp, input string tag);
    bit got;
    if (sb) begin req_b = 1'b1; we_b = w; addr_b = ad; din_b = dn; end
    else    begin req_a = 1'b1; we_a = w; addr_a = ad; din_a = dn; end
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      step();
      got = sb ? gnt_b : gnt_a;
    end
    check({tag, "_gnt"}, int'(got), 1);
    step();
    if (sb) req_b = 1'b0; else req_a = 1'b0;
    if (got && !w) begin
      check({tag, "_valid"}, int'(sb ? valid_b : valid_a), 1);
      check({tag, "_dout"}, int'(sb ? dout_b : dout_a), int'(exp));
    end
    step();
  endtask

  initial begin
    bit         pa, pb, ea, eb;
    logic [2:0] snap;

    // Reset held with random traffic: everything stays quiet
    for (int i = 0; i < 5; i++) begin
      req_a = 1'($urandom); we_a = 1'($urandom); addr_a = 3'($urandom); din_a = 3'($urandom);
      req_b = 1'($urandom); we_b = 1'($urandom); addr_b = 3'($urandom); din_b = 3'($urandom);
      step();
      check("rst_gnt_a", int'(gnt_a), 0);
      check("rst_gnt_b", int'(gnt_b), 0);
      check("rst_valid", int'({valid_a, valid_b}), 0);
      check("rst_dout",  int'({dout_a, dout_b}), 0);
      check("rst_busy",  int'(busy), 0);
    end
    req_a = 1'b0; req_b = 1'b0;
    step();
    rst_n = 1'b1;

    // A only: write 5 to addr 3, then read it back
    req_a = 1'b1; we_a = 1'b1; addr_a = 3'd3; din_a = 3'd5;
    check("a_gnt_early", int'(gnt_a), 0);
    step();
    check("a_gnt_lat", int'(gnt_a), 1);
    check("a_busy", int'(busy), 1);
    step();
    check("a_wr_valid", int'(valid_a), 0);
    we_a = 1'b0;
    step();
    check("a_rd_valid", int'(valid_a), 1);
    check("a_rd_dout", int'(dout_a), 5);
    req_a = 1'b0;
    step();
    check("a_rel_gnt", int'(gnt_a), 0);
    check("a_rel_busy", int'(busy), 0);
    check("a_rel_valid", int'(valid_a), 0);
    check("a_hold_dout", int'(dout_a), 5);

    // Simultaneous requests after reset: A first, 4 commits each, gapless handover
    do_reset();
    req_a = 1'b1; we_a = 1'b0; addr_a = 3'd3;
    req_b = 1'b1; we_b = 1'b0; addr_b = 3'd3;
    pa = 1'b0; pb = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      step();
      ea = (c <= 4) || (c >= 9);
      eb = (c >= 5) && (c <= 8);
      check($sformatf("rr_gnt_a_c%0d", c), int'(gnt_a), int'(ea));
      check($sformatf("rr_gnt_b_c%0d", c), int'(gnt_b), int'(eb));
      check($sformatf("rr_valid_a_c%0d", c), int'(valid_a), int'(pa));
      check($sformatf("rr_valid_b_c%0d", c), int'(valid_b), int'(pb));
      if (pb) check($sformatf("rr_dout_b_c%0d", c), int'(dout_b), 5);
      pa = ea; pb = eb;
    end
    req_a = 1'b0; req_b = 1'b0;
    step();
    check("rr_idle_busy", int'(busy), 0);

    // B alone: 10 back-to-back writes, grant never drops
    req_b = 1'b1; we_b = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      check($sformatf("b_hold_gnt_%0d", i), int'(gnt_b), 1);
      check($sformatf("b_hold_gnt_a_%0d", i), int'(gnt_a), 0);
      addr_b = 3'(i % 8);
      din_b  = 3'((i + 2) % 8);
      step();
    end
    check("b_hold_last", int'(gnt_b), 1);
    req_b = 1'b0;
    step();
    for (int k = 0; k < 8; k++)
      xact(1'b0, 1'b0, 3'(k), 3'd0, (k == 0) ? 3'd2 : (k == 1) ? 3'd3 : 3'((k + 2) % 8),
           $sformatf("b_rb_%0d", k));

    // Cross-port: A writes, B reads, A's read data untouched
    xact(1'b0, 1'b1, 3'd2, 3'd7, 3'd0, "x_wr");
    snap = dout_a;
    xact(1'b1, 1'b0, 3'd2, 3'd0, 3'd7, "x_rd");
    check("x_dout_a_keep", int'(dout_a), int'(snap));

    // Reset while B holds the grant with a pending write: write must be dropped
    xact(1'b0, 1'b1, 3'd4, 3'd1, 3'd0, "pre_wr");
    req_b = 1'b1; we_b = 1'b1; addr_b = 3'd4; din_b = 3'd6;
    step();
    check("ab_gnt_b", int'(gnt_b), 1);
    #2 rst_n = 1'b0;
    #1;
    check("ab_gnt_b_async", int'(gnt_b), 0);
    check("ab_busy_async", int'(busy), 0);
    step();
    check("ab_gnt_b_held", int'(gnt_b), 0);
    check("ab_valid_b", int'(valid_b), 0);
    check("ab_dout_b", int'(dout_b), 0);
    req_b = 1'b0;
    rst_n = 1'b1;
    step();
    xact(1'b1, 1'b0, 3'd4, 3'd0, 3'd1, "ab_rd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
